// File: rtl/bp_out_weight_update.sv
// bp_out_weight_update
// Output-layer backprop engine. It first reads the N_OUT output activations
// from SRAM and forms delta_k = t_k - y_k. It then read-modify-writes every
// hidden->output weight (hidden-major) with w' = sat8(w + ((delta_k*h_j) >>> LR_SHIFT)).
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   run / fin            advance enable (low = pause) / sticky done flag
//   sram_*               shared SRAM bus: address, write data, read data,
//                        tristate drive enable, active-low cs/we/oe strobes
//   t_addr / t           target index out, target value in (one cycle later)
//   hid_addr / hid_act   hidden index out, hidden activation in (one cycle later)
module bp_out_weight_update #(
    parameter int          N_H               = 4,
    parameter int          N_OUT             = 3,
    parameter logic [16:0] ADDR_WO_START     = 17'h00100,
    parameter logic [16:0] ADDR_OUTPUT_START = 17'h00200,
    parameter int          LR_SHIFT          = 8,
    localparam int         KW                = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int         JW                = (N_H > 1) ? $clog2(N_H) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    output logic          fin,
    input  logic [7:0]    sram_read_data,
    output logic [7:0]    sram_write_data,
    output logic [16:0]   sram_addr,
    output logic          sram_data_output_en,
    output logic          sram_cs_n,
    output logic          sram_we_n,
    output logic          sram_oe_n,
    input  logic [7:0]    t,
    output logic [KW-1:0] t_addr,
    input  logic [7:0]    hid_act,
    output logic [JW-1:0] hid_addr
);

    typedef enum logic [2:0] {
        S_IDLE, S_D_WAIT, S_D_CALC, S_W_WAIT, S_W_CALC, S_W_WR, S_W_NEXT, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             fin_q, fin_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [16:0]      addr_q, addr_d;
    logic             de_q, de_d;
    logic             cs_n_q, cs_n_d;
    logic             we_n_q, we_n_d;
    logic             oe_n_q, oe_n_d;
    logic [KW-1:0]    t_addr_q, t_addr_d;
    logic [JW-1:0]    hid_addr_q, hid_addr_d;  // doubles as hidden index j
    logic [KW-1:0]    k_q, k_d;                // output index in the weight phase
    logic signed [8:0] delta_q [N_OUT];
    logic signed [8:0] delta_d [N_OUT];

    // Weight update datapath. 18 bits holds delta*h (|p| <= 65025) and w + u
    // without overflow, so saturation is a simple range compare.
    logic signed [8:0]  dsel;
    logic signed [17:0] prod, upd, sum;
    logic [7:0]         w_new;
    logic               last_k, last_j;

    assign dsel  = delta_q[k_q];
    assign prod  = $signed({{9{dsel[8]}}, dsel}) * $signed({10'b0, hid_act});
    assign upd   = prod >>> LR_SHIFT;
    assign sum   = $signed({{10{sram_read_data[7]}}, sram_read_data}) + upd;
    assign w_new = (sum > 18'sd127)  ? 8'h7f :
                   (sum < -18'sd128) ? 8'h80 : sum[7:0];

    assign last_k = (k_q == KW'(N_OUT - 1));
    assign last_j = (hid_addr_q == JW'(N_H - 1));

    always_comb begin
        state_d    = state_q;
        fin_d      = fin_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        de_d       = de_q;
        cs_n_d     = cs_n_q;
        we_n_d     = we_n_q;
        oe_n_d     = oe_n_q;
        t_addr_d   = t_addr_q;
        hid_addr_d = hid_addr_q;
        k_d        = k_q;
        delta_d    = delta_q;

        // run low freezes every register, strobes included
        if (run) begin
            case (state_q)
                S_IDLE: begin
                    if (!fin_q) begin
                        addr_d   = ADDR_OUTPUT_START;
                        k_d      = '0;
                        t_addr_d = '0;
                        oe_n_d   = 1'b0;
                        we_n_d   = 1'b1;
                        cs_n_d   = 1'b0;
                        state_d  = S_D_WAIT;
                    end
                end
                S_D_WAIT: state_d = S_D_CALC;
                S_D_CALC: begin
                    delta_d[k_q] = $signed({1'b0, t}) - $signed({1'b0, sram_read_data});
                    if (last_k) begin
                        addr_d     = ADDR_WO_START;
                        k_d        = '0;
                        hid_addr_d = '0;
                        t_addr_d   = '0;
                        state_d    = S_W_WAIT;
                    end else begin
                        k_d      = k_q + 1'b1;
                        t_addr_d = t_addr_q + 1'b1;
                        addr_d   = addr_q + 17'd1;
                        state_d  = S_D_WAIT;
                    end
                end
                S_W_WAIT: state_d = S_W_CALC;
                S_W_CALC: begin
                    wdata_d = w_new;
                    de_d    = 1'b1;
                    we_n_d  = 1'b0;
                    state_d = S_W_WR;
                end
                S_W_WR: begin
                    we_n_d  = 1'b1;
                    state_d = S_W_NEXT;
                end
                S_W_NEXT: begin
                    de_d    = 1'b0;
                    wdata_d = 8'h00;
                    if (last_j && last_k) begin
                        state_d = S_DONE;
                    end else if (last_k) begin
                        k_d        = '0;
                        hid_addr_d = hid_addr_q + 1'b1;
                        addr_d     = addr_q + 17'd1;
                        state_d    = S_W_WAIT;
                    end else begin
                        k_d     = k_q + 1'b1;
                        addr_d  = addr_q + 17'd1;
                        state_d = S_W_WAIT;
                    end
                end
                S_DONE: begin
                    fin_d   = 1'b1;
                    addr_d  = '0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fin_q      <= 1'b0;
            wdata_q    <= 8'h00;
            addr_q     <= '0;
            de_q       <= 1'b0;
            cs_n_q     <= 1'b0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b0;
            t_addr_q   <= '0;
            hid_addr_q <= '0;
            k_q        <= '0;
            for (int i = 0; i < N_OUT; i++) delta_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            fin_q      <= fin_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            de_q       <= de_d;
            cs_n_q     <= cs_n_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            t_addr_q   <= t_addr_d;
            hid_addr_q <= hid_addr_d;
            k_q        <= k_d;
            for (int i = 0; i < N_OUT; i++) delta_q[i] <= delta_d[i];
        end
    end

    assign fin                 = fin_q;
    assign sram_write_data     = wdata_q;
    assign sram_addr           = addr_q;
    assign sram_data_output_en = de_q;
    assign sram_cs_n           = cs_n_q;
    assign sram_we_n           = we_n_q;
    assign sram_oe_n           = oe_n_q;
    assign t_addr              = t_addr_q;
    assign hid_addr            = hid_addr_q;

endmodule

// File: tb/tb_bp_out_weight_update.sv
// Directed bench for bp_out_weight_update with N_H=2, N_OUT=2, LR_SHIFT=8.
// Surrounding models: registered-read SRAM, registered target and hidden lookups.
module tb_bp_out_weight_update;

    logic        clk = 1'b0;
    logic        reset, run, fin;
    logic [7:0]  sram_read_data, sram_write_data;
    logic [16:0] sram_addr;
    logic        sram_data_output_en, sram_cs_n, sram_we_n, sram_oe_n;
    logic [7:0]  t, hid_act;
    logic [0:0]  t_addr, hid_addr;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  mem [0:1023];
    logic [7:0]  tgt [2];
    logic [7:0]  hid [2];
    logic        ld_en = 1'b0;
    logic [9:0]  ld_addr = '0;
    logic [7:0]  ld_data = '0;

    always #5 clk = ~clk;

    bp_out_weight_update #(
        .N_H(2), .N_OUT(2), .ADDR_WO_START(17'h00100),
        .ADDR_OUTPUT_START(17'h00200), .LR_SHIFT(8)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .fin(fin),
        .sram_read_data(sram_read_data), .sram_write_data(sram_write_data),
        .sram_addr(sram_addr), .sram_data_output_en(sram_data_output_en),
        .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .t(t), .t_addr(t_addr), .hid_act(hid_act), .hid_addr(hid_addr)
    );

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (!sram_cs_n && !sram_we_n) mem[sram_addr[9:0]] <= sram_write_data;
        sram_read_data <= mem[sram_addr[9:0]];
        t              <= tgt[t_addr];
        hid_act        <= hid[hid_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hold reset, load y0,y1 and the four weights, release with run low.
    task automatic setup(input logic [7:0] y0, input logic [7:0] y1,
                         input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input logic [7:0] w3);
        logic [9:0] a [6];
        logic [7:0] d [6];
        a = '{10'h200, 10'h201, 10'h100, 10'h101, 10'h102, 10'h103};
        d = '{y0, y1, w0, w1, w2, w3};
        @(negedge clk); reset = 1'b1; run = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); ld_en = 1'b1; ld_addr = a[i]; ld_data = d[i];
        end
        @(negedge clk); ld_en = 1'b0;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic chk_img(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3);
        chk({tag, "_w00"}, mem[10'h100], w0);
        chk({tag, "_w01"}, mem[10'h101], w1);
        chk({tag, "_w10"}, mem[10'h102], w2);
        chk({tag, "_w11"}, mem[10'h103], w3);
    endtask

    // Raise run and count edges until fin; optionally pause 5 cycles while
    // the pause_wr-th write strobe is low.
    task automatic do_run(input int pause_wr, output int edges, output int nwr);
        logic        prev_we;
        logic [16:0] pa;
        logic        pw, pd;
        edges = 0; nwr = 0; prev_we = 1'b1;
        @(negedge clk); run = 1'b1;
        while (!fin && edges < 300) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if (prev_we && !sram_we_n) begin
                nwr++;
                if (nwr == pause_wr) begin
                    run = 1'b0;
                    pa = sram_addr; pw = sram_we_n; pd = sram_data_output_en;
                    repeat (5) begin
                        @(posedge clk); edges++;
                        @(negedge clk);
                        chk("pause_addr", sram_addr, pa);
                        chk("pause_we_n", sram_we_n, pw);
                        chk("pause_de", sram_data_output_en, pd);
                    end
                    run = 1'b1;
                end
            end
            prev_we = sram_we_n;
        end
        if (!fin) chk("fin_timeout", 32'd0, 32'd1);
        run = 1'b0;
    endtask

    int e, nw;

    initial begin
        reset = 1'b1; run = 1'b1;
        tgt = '{8'd0, 8'd0}; hid = '{8'd0, 8'd0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_fin", fin, 0);
        chk("rst_wdata", sram_write_data, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_de", sram_data_output_en, 0);
        chk("rst_cs_n", sram_cs_n, 0);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_oe_n", sram_oe_n, 0);
        chk("rst_t_addr", t_addr, 0);
        chk("rst_hid_addr", hid_addr, 0);
        reset = 1'b0; run = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_addr", sram_addr, 0);
            chk("idle_we_n", sram_we_n, 1);
            chk("idle_fin", fin, 0);
        end

        // Zero error: every weight rewritten unchanged
        tgt = '{8'd50, 8'd60}; hid = '{8'd10, 8'd200};
        setup(8'd50, 8'd60, 8'h01, 8'hFE, 8'h03, 8'hFC);
        do_run(0, e, nw);
        chk("zero_fin_edge", e, 22);
        chk("zero_writes", nw, 4);
        chk_img("zero", 8'h01, 8'hFE, 8'h03, 8'hFC);
        repeat (3) @(negedge clk);
        chk("fin_sticky", fin, 1);

        // delta={100,-255}, h={255,128}: 10->109, -100->-128, -5->45, 50->-78
        tgt = '{8'd200, 8'd0}; hid = '{8'd255, 8'd128};
        setup(8'd100, 8'd255, 8'd10, 8'h9C, 8'hFB, 8'd50);
        do_run(0, e, nw);
        chk("upd_fin_edge", e, 22);
        chk_img("upd", 8'h6D, 8'h80, 8'h2D, 8'hB2);

        // Same pass, paused 5 cycles in W_WR of weight (1,0)
        setup(8'd100, 8'd255, 8'd10, 8'h9C, 8'hFB, 8'd50);
        do_run(3, e, nw);
        chk("pause_fin_edge", e, 27);
        chk("pause_writes", nw, 4);
        chk_img("pause", 8'h6D, 8'h80, 8'h2D, 8'hB2);

        // delta={255,-7}, h={255,1}: 120->127, 0->-7, 7->7, 7->6 (floor)
        tgt = '{8'd255, 8'd3}; hid = '{8'd255, 8'd1};
        setup(8'd0, 8'd10, 8'd120, 8'h00, 8'h07, 8'h07);
        do_run(0, e, nw);
        chk_img("sat", 8'h7F, 8'hF9, 8'h07, 8'h06);

        // Reset during W_CALC of weight (0,1) (after edge 10)
        setup(8'd0, 8'd10, 8'd120, 8'h00, 8'h07, 8'h07);
        @(negedge clk); run = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("mid_addr_w01", sram_addr, 17'h00101);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_we_n", sram_we_n, 1);
        chk("mid_de", sram_data_output_en, 0);
        chk("mid_addr", sram_addr, 0);
        reset = 1'b0; run = 1'b0;
        repeat (2) @(negedge clk);
        chk_img("mid", 8'h7F, 8'h00, 8'h07, 8'h07);
        do_run(0, e, nw);
        chk("rerun_fin_edge", e, 22);
        chk_img("rerun", 8'h7F, 8'hF9, 8'h07, 8'h06);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
